stack_frame_controller: RTL and testbench

- Sits directly upstream of SuperStack and is the sole driver of its `op`, `data` and `underflow_limit` inputs.
- Forwards plain stack commands from the execution core (PUSH/POP/REPLACE) with zero added latency.
- Implements WebAssembly CALL/RETURN frame semantics:
  - CALL moves the underflow limit so the callee sees only its arguments.
  - RETURN drops callee locals, restores the caller limit and re-pushes an optional single result.

---
 rtl/stack_frame_controller_pkg.sv | 36 +++
 rtl/stack_frame_controller_frame_lifo.sv | 45 ++++
 rtl/stack_frame_controller.sv | 179 +++++++++++++++++
 tb/tb_stack_frame_controller.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_frame_controller_pkg.sv
// Shared encodings for the stack frame controller: command, SuperStack op,
// error code and FSM state types.
package stack_frame_controller_pkg;

    typedef enum logic [2:0] {
        CMD_NOP     = 3'd0,
        CMD_PUSH    = 3'd1,
        CMD_POP     = 3'd2,
        CMD_REPLACE = 3'd3,
        CMD_CALL    = 3'd4,
        CMD_RETURN  = 3'd5
    } cmd_e;

    // Same encodings as the SuperStack op input
    typedef enum logic [1:0] {
        STK_NONE    = 2'd0,
        STK_PUSH    = 2'd1,
        STK_POP     = 2'd2,
        STK_REPLACE = 2'd3
    } stk_op_e;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_OVERFLOW        = 3'd1,
        ERR_UNDERFLOW       = 3'd2,
        ERR_FRAME_OVERFLOW  = 3'd3,
        ERR_FRAME_UNDERFLOW = 3'd4
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RET_DROP = 2'd1,
        ST_RET_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/stack_frame_controller_frame_lifo.sv
// FRAMES-deep LIFO holding the caller underflow limits saved by CALL.
module stack_frame_controller_frame_lifo #(
    parameter int FRAMES = 4,
    parameter int EW     = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [EW-1:0] din,
    output logic          full,
    output logic          empty,
    output logic [EW-1:0] top
);

    localparam int CW = $clog2(FRAMES + 1);

    logic [EW-1:0] mem_q [FRAMES];
    logic [CW-1:0] cnt_q;

    assign full  = (cnt_q == CW'(FRAMES));
    assign empty = (cnt_q == '0);

    always_comb begin
        top = '0;
        for (int i = 0; i < FRAMES; i++) begin
            if (CW'(i + 1) == cnt_q) top = mem_q[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            for (int i = 0; i < FRAMES; i++) mem_q[i] <= '0;
        end else if (push && !full) begin
            for (int i = 0; i < FRAMES; i++) begin
                if (CW'(i) == cnt_q) mem_q[i] <= din;
            end
            cnt_q <= cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/stack_frame_controller.sv
// Drives SuperStack op/data/underflow_limit: forwards plain stack commands in the
// accept cycle and sequences WebAssembly CALL/RETURN frame changes.
module stack_frame_controller
    import stack_frame_controller_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 1,
    parameter int FRAMES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       cmd,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [DEPTH:0]   cmd_args,
    input  logic             cmd_results,
    output logic [1:0]       stk_op,
    output logic [WIDTH-1:0] stk_data,
    output logic [DEPTH:0]   underflow_limit,
    input  logic [WIDTH-1:0] stk_tos,
    output logic [DEPTH:0]   index,
    output logic             err,
    output logic [2:0]       err_code
);

    // state       | meaning
    // ST_IDLE     | accepting commands; plain ops forwarded combinationally
    // ST_RET_DROP | RETURN: popping callee operands down to the callee limit
    // ST_RET_FIN  | RETURN: restore caller limit, re-push result if any

    localparam int IW = DEPTH + 1;
    localparam logic [IW-1:0] CAP = '1;

    state_e           state_q;
    logic [IW-1:0]    index_q;
    logic [IW-1:0]    limit_q;
    logic [WIDTH-1:0] result_q;
    logic             res_flag_q;
    logic             err_q;
    err_e             err_code_q;

    cmd_e             cmd_t;
    err_e             rej;
    logic             accept;
    logic             ok;
    logic [IW-1:0]    avail;
    logic [IW-1:0]    index_inc;
    logic [IW-1:0]    index_dec;
    logic             frame_full;
    logic             frame_empty;
    logic [IW-1:0]    frame_top;

    assign cmd_t     = cmd_e'(cmd);
    assign accept    = cmd_valid && (state_q == ST_IDLE) && !reset;
    assign ok        = accept && (rej == ERR_NONE);
    // index never drops below limit, so this difference cannot wrap
    assign avail     = index_q - limit_q;
    assign index_inc = index_q + IW'(1);
    assign index_dec = index_q - IW'(1);

    always_comb begin
        rej = ERR_NONE;
        case (cmd_t)
            CMD_PUSH: begin
                if (index_q == CAP) rej = ERR_OVERFLOW;
            end
            CMD_POP, CMD_REPLACE: begin
                if (index_q == limit_q) rej = ERR_UNDERFLOW;
            end
            CMD_CALL: begin
                if (frame_full)             rej = ERR_FRAME_OVERFLOW;
                else if (cmd_args > avail)  rej = ERR_UNDERFLOW;
            end
            CMD_RETURN: begin
                if (frame_empty)                            rej = ERR_FRAME_UNDERFLOW;
                else if (cmd_results && index_q == limit_q) rej = ERR_UNDERFLOW;
            end
            default: ;
        endcase
    end

    always_comb begin
        stk_op   = STK_NONE;
        stk_data = '0;
        case (state_q)
            ST_IDLE: begin
                if (ok) begin
                    case (cmd_t)
                        CMD_PUSH: begin
                            stk_op   = STK_PUSH;
                            stk_data = cmd_data;
                        end
                        CMD_POP: stk_op = STK_POP;
                        CMD_REPLACE: begin
                            stk_op   = STK_REPLACE;
                            stk_data = cmd_data;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RET_DROP: stk_op = STK_POP;
            ST_RET_FIN: begin
                if (res_flag_q) begin
                    stk_op   = STK_PUSH;
                    stk_data = result_q;
                end
            end
            default: ;
        endcase
    end

    stack_frame_controller_frame_lifo #(
        .FRAMES (FRAMES),
        .EW     (IW)
    ) u_frame_lifo (
        .clk   (clk),
        .reset (reset),
        .push  (ok && cmd_t == CMD_CALL),
        .pop   (state_q == ST_RET_FIN),
        .din   (limit_q),
        .full  (frame_full),
        .empty (frame_empty),
        .top   (frame_top)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            index_q    <= '0;
            limit_q    <= '0;
            result_q   <= '0;
            res_flag_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            case (state_q)
                ST_IDLE: begin
                    if (accept && rej != ERR_NONE) begin
                        err_q      <= 1'b1;
                        err_code_q <= rej;
                    end else if (ok) begin
                        case (cmd_t)
                            CMD_PUSH: index_q <= index_inc;
                            CMD_POP:  index_q <= index_dec;
                            CMD_CALL: limit_q <= index_q - cmd_args;
                            CMD_RETURN: begin
                                result_q   <= stk_tos;
                                res_flag_q <= cmd_results;
                                state_q    <= (index_q > limit_q) ? ST_RET_DROP : ST_RET_FIN;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RET_DROP: begin
                    index_q <= index_dec;
                    if (index_dec == limit_q) state_q <= ST_RET_FIN;
                end
                ST_RET_FIN: begin
                    limit_q <= frame_top;
                    if (res_flag_q) index_q <= index_inc;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready       = (state_q == ST_IDLE);
    assign underflow_limit = limit_q;
    assign index           = index_q;
    assign err             = err_q;
    assign err_code        = err_code_q;

endmodule

// File: tb/tb_stack_frame_controller.sv
// Bench for stack_frame_controller: directed frame scenarios plus random command
// streams compared cycle by cycle against a queue-based stack/frame model.
module tb_stack_frame_controller;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 1;
    localparam int FRAMES = 2;
    localparam int IW     = DEPTH + 1;
    localparam int CAP    = (1 << IW) - 1;

    localparam int C_NOP = 0, C_PUSH = 1, C_POP = 2, C_REPL = 3, C_CALL = 4, C_RET = 5;
    localparam int O_NONE = 0, O_PUSH = 1, O_POP = 2, O_REPL = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [2:0]       cmd = '0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [DEPTH:0]   cmd_args = '0;
    logic             cmd_results = 1'b0;
    logic [1:0]       stk_op;
    logic [WIDTH-1:0] stk_data;
    logic [DEPTH:0]   underflow_limit;
    logic [WIDTH-1:0] stk_tos = '0;
    logic [DEPTH:0]   index;
    logic             err;
    logic [2:0]       err_code;

    stack_frame_controller #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FRAMES(FRAMES)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd             (cmd),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_data        (cmd_data),
        .cmd_args        (cmd_args),
        .cmd_results     (cmd_results),
        .stk_op          (stk_op),
        .stk_data        (stk_data),
        .underflow_limit (underflow_limit),
        .stk_tos         (stk_tos),
        .index           (index),
        .err             (err),
        .err_code        (err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op;
        int data;
        int ready;
        int index;
        int limit;
        int err;
        int code;
    } rec_t;

    rec_t expq[$];
    int   oplog[$];
    int   datalog[$];
    int   rdylog[$];

    int checks = 0;
    int errors = 0;

    // Model: operand stack contents, current limit, saved limits, pending error
    int mstk[$];
    int mframes[$];
    int mlimit = 0;
    int perr = 0;
    int pcode = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (expq.size() > 0) begin
            r = expq.pop_front();
            oplog.push_back(int'(stk_op));
            datalog.push_back(int'(stk_data));
            rdylog.push_back(int'(cmd_ready));
            check("stk_op", int'(stk_op), r.op);
            if (r.op == O_PUSH || r.op == O_REPL) check("stk_data", int'(stk_data), r.data);
            check("cmd_ready", int'(cmd_ready), r.ready);
            check("index", int'(index), r.index);
            check("underflow_limit", int'(underflow_limit), r.limit);
            check("err", int'(err), r.err);
            if (r.err != 0) check("err_code", int'(err_code), r.code);
        end
    end

    task automatic step(input rec_t r);
        expq.push_back(r);
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mstk.delete();
        mframes.delete();
        mlimit = 0;
        perr = 0;
        pcode = 0;
    endtask

    // Called 1 time unit after a rising edge; returns at the same phase.
    task automatic issue(input int c, input int d, input int a, input int res, input bit v);
        rec_t r;
        int   idx;
        int   tos;
        int   nerr;
        int   ncode;
        int   result;
        int   hold;
        nerr  = 0;
        ncode = 0;
        idx   = mstk.size();
        tos   = (idx > 0) ? mstk[idx-1] : 0;
        stk_tos     = WIDTH'(tos);
        cmd         = 3'(c);
        cmd_data    = WIDTH'(d);
        cmd_args    = IW'(a);
        cmd_results = 1'(res);
        cmd_valid   = v;
        r.op = O_NONE; r.data = 0; r.ready = 1; r.index = idx; r.limit = mlimit;
        r.err = perr; r.code = pcode;
        if (v) begin
            case (c)
                C_PUSH: if (idx == CAP) begin nerr = 1; ncode = 1; end
                        else begin r.op = O_PUSH; r.data = d; mstk.push_back(d); end
                C_POP:  if (idx == mlimit) begin nerr = 1; ncode = 2; end
                        else begin r.op = O_POP; void'(mstk.pop_back()); end
                C_REPL: if (idx == mlimit) begin nerr = 1; ncode = 2; end
                        else begin r.op = O_REPL; r.data = d; mstk[idx-1] = d; end
                C_CALL: if (mframes.size() == FRAMES) begin nerr = 1; ncode = 3; end
                        else if (a > idx - mlimit) begin nerr = 1; ncode = 2; end
                        else begin mframes.push_back(mlimit); mlimit = idx - a; end
                C_RET: begin
                    if (mframes.size() == 0) begin nerr = 1; ncode = 4; end
                    else if (res != 0 && idx == mlimit) begin nerr = 1; ncode = 2; end
                    else begin
                        result = tos;
                        hold   = res;
                        perr   = 0;
                        pcode  = 0;
                        step(r);
                        // presented while busy: must be ignored
                        cmd       = 3'(C_PUSH);
                        cmd_data  = WIDTH'($urandom_range(0, 255));
                        cmd_valid = 1'b1;
                        while (mstk.size() > mlimit) begin
                            r.op = O_POP; r.ready = 0; r.index = mstk.size(); r.limit = mlimit;
                            r.err = 0;
                            step(r);
                            void'(mstk.pop_back());
                        end
                        r.op = hold ? O_PUSH : O_NONE; r.data = result; r.ready = 0;
                        r.index = mstk.size(); r.limit = mlimit; r.err = 0;
                        step(r);
                        mlimit = mframes.pop_back();
                        if (hold != 0) mstk.push_back(result);
                        cmd_valid = 1'b0;
                        return;
                    end
                end
                default: ;
            endcase
        end
        perr  = nerr;
        pcode = ncode;
        step(r);
        cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic clear_logs();
        oplog.delete();
        datalog.delete();
        rdylog.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c, sel, v;
        #1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_index", int'(index), 0);
        check("rst_limit", int'(underflow_limit), 0);
        check("rst_op", int'(stk_op), 0);
        check("rst_data", int'(stk_data), 0);
        check("rst_err", int'(err), 0);
        check("rst_code", int'(err_code), 0);
        reset = 1'b0;
        model_clear();

        // push past capacity
        issue(C_PUSH, 8'h0A, 0, 0, 1); check("push1_index", int'(index), 1);
        issue(C_PUSH, 8'h0B, 0, 0, 1); check("push2_index", int'(index), 2);
        issue(C_PUSH, 8'h0C, 0, 0, 1); check("push3_index", int'(index), 3);
        issue(C_PUSH, 8'h0D, 0, 0, 1);
        check("ovf_err", int'(err), 1);
        check("ovf_code", int'(err_code), 1);
        check("ovf_index", int'(index), 3);

        // CALL with one argument, pop it twice
        issue(C_CALL, 0, 1, 0, 1); check("call1_limit", int'(underflow_limit), 2);
        issue(C_POP, 0, 0, 0, 1);  check("pop1_index", int'(index), 2);
        issue(C_POP, 0, 0, 0, 1);
        check("pop2_err", int'(err), 1);
        check("pop2_code", int'(err_code), 2);

        // RETURN with a result from index 3, limit 1
        do_reset();
        issue(C_PUSH, 8'h0A, 0, 0, 1);
        issue(C_PUSH, 8'h0B, 0, 0, 1);
        issue(C_PUSH, 8'h0C, 0, 0, 1);
        issue(C_CALL, 0, 2, 0, 1); check("call2_limit", int'(underflow_limit), 1);
        clear_logs();
        issue(C_RET, 0, 0, 1, 1);
        check("ret1_len", oplog.size(), 4);
        check("ret1_op0", oplog[0], O_NONE);
        check("ret1_op1", oplog[1], O_POP);
        check("ret1_op2", oplog[2], O_POP);
        check("ret1_op3", oplog[3], O_PUSH);
        check("ret1_data3", datalog[3], 8'h0C);
        check("ret1_rdy_low", rdylog[1] + rdylog[2] + rdylog[3], 0);
        check("ret1_ready", int'(cmd_ready), 1);
        check("ret1_limit", int'(underflow_limit), 0);
        check("ret1_index", int'(index), 2);

        // RETURN without result and no locals
        issue(C_CALL, 0, 0, 0, 1);
        clear_logs();
        issue(C_RET, 0, 0, 0, 1);
        check("ret2_len", oplog.size(), 2);
        check("ret2_op0", oplog[0], O_NONE);
        check("ret2_op1", oplog[1], O_NONE);
        check("ret2_rdy1", rdylog[1], 0);
        check("ret2_ready", int'(cmd_ready), 1);
        check("ret2_limit", int'(underflow_limit), 0);

        // frame stack boundaries
        issue(C_CALL, 0, 0, 0, 1);
        issue(C_CALL, 0, 0, 0, 1);
        issue(C_CALL, 0, 0, 0, 1);
        check("fovf_err", int'(err), 1);
        check("fovf_code", int'(err_code), 3);
        issue(C_RET, 0, 0, 0, 1);
        issue(C_RET, 0, 0, 0, 1);
        check("fret_limit", int'(underflow_limit), 0);
        issue(C_RET, 0, 0, 0, 1);
        check("fund_err", int'(err), 1);
        check("fund_code", int'(err_code), 4);

        // random command stream
        do_reset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0:       c = C_NOP;
                1, 2, 3: c = C_PUSH;
                4, 5:    c = C_POP;
                6:       c = C_REPL;
                7:       c = C_CALL;
                default: c = C_RET;
            endcase
            v = ($urandom_range(0, 7) != 0) ? 1 : 0;
            issue(c, $urandom_range(0, 255), $urandom_range(0, CAP), $urandom_range(0, 1), 1'(v));
        end
        issue(C_NOP, 0, 0, 0, 0);

        // reset asserted during RET_DROP
        do_reset();
        issue(C_PUSH, 8'h11, 0, 0, 1);
        issue(C_PUSH, 8'h22, 0, 0, 1);
        issue(C_PUSH, 8'h33, 0, 0, 1);
        issue(C_CALL, 0, 3, 0, 1);
        check("rm_limit", int'(underflow_limit), 0);
        begin
            rec_t r;
            stk_tos = 8'h33;
            cmd = 3'(C_RET); cmd_results = 1'b0; cmd_valid = 1'b1;
            r.op = O_NONE; r.data = 0; r.ready = 1; r.index = 3; r.limit = 0;
            r.err = perr; r.code = pcode;
            expq.push_back(r);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            check("rm_drop_op", int'(stk_op), O_POP);
            #2;
            reset = 1'b1;
            #1;
            check("rm_op", int'(stk_op), O_NONE);
            check("rm_index", int'(index), 0);
            check("rm_limit0", int'(underflow_limit), 0);
            check("rm_ready", int'(cmd_ready), 1);
            @(posedge clk);
            #1;
            reset = 1'b0;
            model_clear();
        end
        issue(C_PUSH, 8'h05, 0, 0, 1);
        check("rm_push_index", int'(index), 1);
        issue(C_NOP, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
